// File: rtl/alu_op_issue_pkg.sv
// alu_op_issue_pkg: ALU control codes, ALUOp codes and R-type opcode constants
// shared by the issue stage, the ALU and the main control unit.
package alu_op_issue_pkg;

    localparam int DATA_W = 64;
    localparam int OPC_W  = 11;

    typedef enum logic [3:0] {
        ALU_AND   = 4'h0,
        ALU_OR    = 4'h1,
        ALU_ADD   = 4'h2,
        ALU_SUB   = 4'h6,
        ALU_PASSB = 4'h7,
        ALU_ILL   = 4'hF
    } aluCtrl_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_PASSB = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_ILL   = 2'b11
    } aluOp_e;

    localparam logic [OPC_W-1:0] OPC_ADD = 11'b10001011000;
    localparam logic [OPC_W-1:0] OPC_SUB = 11'b11001011000;
    localparam logic [OPC_W-1:0] OPC_AND = 11'b10001010000;
    localparam logic [OPC_W-1:0] OPC_ORR = 11'b10101010000;

endpackage

// File: rtl/alu_op_issue_if.sv
// alu_op_issue_if: decode-side operand bundle and ALU-side operand bus of the
// issue stage. master = surrounding pipeline, slave = issue stage.
interface alu_op_issue_if #(
    parameter int WIDTH = 64,
    parameter int OPC_W = 11
);
    // decode -> issue
    logic             InValid;
    logic             InReady;
    logic [1:0]       ALUOp;
    logic [OPC_W-1:0] Opcode;
    logic             ALUSrc;
    logic [WIDTH-1:0] RegA;
    logic [WIDTH-1:0] RegB;
    logic [WIDTH-1:0] Imm;
    // issue -> ALU
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] BusA;
    logic [WIDTH-1:0] BusB;
    logic [3:0]       ALUCtrl;

    modport master (
        output InValid, ALUOp, Opcode, ALUSrc, RegA, RegB, Imm, OutReady,
        input  InReady, OutValid, BusA, BusB, ALUCtrl
    );

    modport slave (
        input  InValid, ALUOp, Opcode, ALUSrc, RegA, RegB, Imm, OutReady,
        output InReady, OutValid, BusA, BusB, ALUCtrl
    );
endinterface

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational {ALUOp, Opcode} -> {ALUCtrl, Illegal}.
module alu_ctrl_decode
    import alu_op_issue_pkg::*;
#(
    parameter int OPC_W = 11
) (
    input  logic [1:0]       ALUOp,
    input  logic [OPC_W-1:0] Opcode,
    output aluCtrl_e         ALUCtrl,
    output logic             Illegal
);

    // Map the control class (and the R-type opcode) to an ALU function.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        ALUCtrl = ALU_ILL;
        Illegal = 1'b1;
        case (ALUOp)
            ALUOP_ADD:   begin ALUCtrl = ALU_ADD;   Illegal = 1'b0; end
            ALUOP_PASSB: begin ALUCtrl = ALU_PASSB; Illegal = 1'b0; end
            ALUOP_RTYPE: begin
                case (Opcode)
                    OPC_ADD: begin ALUCtrl = ALU_ADD; Illegal = 1'b0; end
                    OPC_SUB: begin ALUCtrl = ALU_SUB; Illegal = 1'b0; end
                    OPC_AND: begin ALUCtrl = ALU_AND; Illegal = 1'b0; end
                    OPC_ORR: begin ALUCtrl = ALU_OR;  Illegal = 1'b0; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_op_issue.sv
// alu_op_issue: issue stage ahead of the 64-bit ALU. Decodes ALUCtrl, selects
// BusB, and holds ops in a 2-entry output + skid buffer so decode can stall
// independently of execute.
// Optional feature: define ALU_ISSUE_ILLEGAL_TRAP_EN to drop illegal ops and
// raise sticky IllegalOp; otherwise illegal ops issue with ALUCtrl = 4'hF.
module alu_op_issue
    import alu_op_issue_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int OPC_W = alu_op_issue_pkg::OPC_W
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          Flush,
    alu_op_issue_if.slave bus,
    output logic          IllegalOp
);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [3:0]       ctrl;
    } entry_t;

    entry_t   outReg, skidReg, inEntry;
    logic     outValid, skidValid;
    aluCtrl_e decCtrl;
    logic     decIllegal;
    logic     accept, push, consume, outFree;

    alu_ctrl_decode #(.OPC_W(OPC_W)) uDecode (
        .ALUOp   (bus.ALUOp),
        .Opcode  (bus.Opcode),
        .ALUCtrl (decCtrl),
        .Illegal (decIllegal)
    );

    // Operand bundle as it would be stored; illegal ops always carry the trap code.
    assign inEntry.a    = bus.RegA;
    assign inEntry.b    = bus.ALUSrc ? bus.Imm : bus.RegB;
    assign inEntry.ctrl = decIllegal ? ALU_ILL : decCtrl;

    // InReady is purely the registered skid state; an op offered during Flush is dropped.
    assign accept  = bus.InValid & ~skidValid & ~Flush;
    assign consume = outValid & bus.OutReady;
    assign outFree = ~outValid | consume;

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    assign push = accept & ~decIllegal;
`else
    assign push = accept;
`endif

    // Output/skid buffer: refill output from skid first (FIFO order), else from input.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            // NOTE: the data registers are reset too, because BusA/BusB/ALUCtrl must read 0 out of reset.
            outValid  <= 1'b0;
            skidValid <= 1'b0;
            outReg    <= '0;
            skidReg   <= '0;
        end else if (Flush) begin
            outValid  <= 1'b0;
            skidValid <= 1'b0;
        end else if (outFree) begin
            if (skidValid) begin
                // NOTE: non-blocking updates so every register sees pre-edge values of the others.
                outReg    <= skidReg;
                outValid  <= 1'b1;
                skidValid <= 1'b0;
            end else begin
                outValid <= push;
                if (push) outReg <= inEntry;
            end
        end else if (push) begin
            skidReg   <= inEntry;
            skidValid <= 1'b1;
        end
    end

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    // Sticky illegal-op flag; only Reset clears it.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset)                      IllegalOp <= 1'b0;
        else if (accept && decIllegal)  IllegalOp <= 1'b1;
    end
`else
    assign IllegalOp = 1'b0;
`endif

    assign bus.InReady  = ~skidValid;
    assign bus.OutValid = outValid;
    assign bus.BusA     = outReg.a;
    assign bus.BusB     = outReg.b;
    assign bus.ALUCtrl  = outReg.ctrl;

endmodule

// File: tb/tb_alu_op_issue.sv
// tb_alu_op_issue: directed self-checking bench for alu_op_issue. Inputs are
// driven and outputs sampled 1 time unit after the rising clock edge.
module tb_alu_op_issue;
    import alu_op_issue_pkg::*;

    logic CLK = 1'b0;
    logic Reset;
    logic Flush;
    logic IllegalOp;
    int   compared = 0;
    int   mismatched = 0;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  ctrl;
    } exp_t;

    exp_t expQ[$];

    alu_op_issue_if #(.WIDTH(64), .OPC_W(11)) bus ();

    alu_op_issue #(.WIDTH(64), .OPC_W(11)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .Flush     (Flush),
        .bus       (bus),
        .IllegalOp (IllegalOp)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic valid, input logic [1:0] op, input logic [10:0] opc,
                         input logic src, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] imm);
        bus.InValid = valid;
        bus.ALUOp   = op;
        bus.Opcode  = opc;
        bus.ALUSrc  = src;
        bus.RegA    = a;
        bus.RegB    = b;
        bus.Imm     = imm;
    endtask

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Flush = 1'b0;
        bus.OutReady = 1'b0;
        drive(1'b0, 2'b00, 11'd0, 1'b0, 64'd0, 64'd0, 64'd0);
        #1;
        cmp("reset OutValid", {63'd0, bus.OutValid}, 64'd0);
        cmp("reset InReady", {63'd0, bus.InReady}, 64'd1);
        cmp("reset BusA", bus.BusA, 64'd0);
        cmp("reset BusB", bus.BusB, 64'd0);
        cmp("reset ALUCtrl", {60'd0, bus.ALUCtrl}, 64'd0);
        cmp("reset IllegalOp", {63'd0, IllegalOp}, 64'd0);
        repeat (2) step();
        Reset = 1'b0;
    endtask

    task automatic test_rtype_add();
        bus.OutReady = 1'b1;
        drive(1'b1, 2'b10, 11'b10001011000, 1'b0, 64'h1234, 64'hABCD0000, 64'hFFFF);
        step();
        cmp("rtype OutValid", {63'd0, bus.OutValid}, 64'd1);
        cmp("rtype ALUCtrl", {60'd0, bus.ALUCtrl}, 64'd2);
        cmp("rtype BusA", bus.BusA, 64'h1234);
        cmp("rtype BusB", bus.BusB, 64'hABCD0000);
    endtask

    task automatic test_imm_passb();
        // consume of the previous op and accept of this one share an edge
        drive(1'b1, 2'b00, 11'd0, 1'b1, 64'h55, 64'h77, 64'd8);
        step();
        cmp("ldst ALUCtrl", {60'd0, bus.ALUCtrl}, 64'd2);
        cmp("ldst BusB imm", bus.BusB, 64'd8);
        cmp("ldst BusA", bus.BusA, 64'h55);
        drive(1'b1, 2'b01, 11'd0, 1'b0, 64'h1, 64'hFFFF_FFFF_FFFF_FFF8, 64'd3);
        step();
        cmp("cbz ALUCtrl", {60'd0, bus.ALUCtrl}, 64'd7);
        cmp("cbz BusB regb", bus.BusB, 64'hFFFF_FFFF_FFFF_FFF8);
        drive(1'b1, 2'b10, 11'b11001011000, 1'b0, 64'h2, 64'h3, 64'd0);
        step();
        cmp("sub ALUCtrl", {60'd0, bus.ALUCtrl}, 64'd6);
        drive(1'b1, 2'b10, 11'b10001010000, 1'b0, 64'h2, 64'h3, 64'd0);
        step();
        cmp("and ALUCtrl", {60'd0, bus.ALUCtrl}, 64'd0);
        drive(1'b1, 2'b10, 11'b10101010000, 1'b0, 64'h2, 64'h3, 64'd0);
        step();
        cmp("orr ALUCtrl", {60'd0, bus.ALUCtrl}, 64'd1);
        bus.InValid = 1'b0;
        step();
        cmp("drained OutValid", {63'd0, bus.OutValid}, 64'd0);
    endtask

    task automatic test_backpressure();
        bus.OutReady = 1'b0;
        drive(1'b1, 2'b00, 11'd0, 1'b0, 64'hA, 64'hA0, 64'd0);
        step();
        cmp("bp A OutValid", {63'd0, bus.OutValid}, 64'd1);
        cmp("bp InReady after A", {63'd0, bus.InReady}, 64'd1);
        drive(1'b1, 2'b01, 11'd0, 1'b0, 64'hB, 64'hB0, 64'd0);
        step();
        bus.InValid = 1'b0;
        cmp("bp InReady after B", {63'd0, bus.InReady}, 64'd0);
        cmp("bp A held", bus.BusA, 64'hA);
        step();
        cmp("bp A still held", bus.BusA, 64'hA);
        cmp("bp A ctrl held", {60'd0, bus.ALUCtrl}, 64'd2);
        bus.OutReady = 1'b1;
        step();
        cmp("bp B BusA", bus.BusA, 64'hB);
        cmp("bp B ctrl", {60'd0, bus.ALUCtrl}, 64'd7);
        cmp("bp B OutValid", {63'd0, bus.OutValid}, 64'd1);
        cmp("bp InReady restored", {63'd0, bus.InReady}, 64'd1);
        step();
        cmp("bp empty", {63'd0, bus.OutValid}, 64'd0);
    endtask

    task automatic test_back_to_back();
        bus.OutReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b00, 11'd0, 1'b0, 64'h100 + 64'(i), 64'd0, 64'd0);
            step();
            cmp("b2b BusA", bus.BusA, 64'h100 + 64'(i));
            cmp("b2b InReady", {63'd0, bus.InReady}, 64'd1);
        end
        bus.InValid = 1'b0;
        step();
    endtask

    task automatic test_stream();
        logic [10:0] opcTab [4];
        logic [3:0]  ctrlTab [4];
        int   sent = 0;
        int   recv = 0;
        int   budget = 3000;
        exp_t e;
        opcTab[0] = 11'b10001011000; ctrlTab[0] = 4'h2;
        opcTab[1] = 11'b11001011000; ctrlTab[1] = 4'h6;
        opcTab[2] = 11'b10001010000; ctrlTab[2] = 4'h0;
        opcTab[3] = 11'b10101010000; ctrlTab[3] = 4'h1;
        expQ.delete();
        while (recv < 100 && budget > 0) begin
            budget--;
            bus.OutReady = 1'($urandom_range(0, 1));
            bus.InValid  = (sent < 100) && ($urandom_range(0, 3) != 0);
            bus.RegA     = 64'hA000_0000_0000_0000 + 64'(sent);
            bus.RegB     = 64'hB000_0000_0000_0000 + 64'(sent * 3);
            bus.Imm      = 64'(sent) << 8;
            bus.ALUSrc   = sent[0];
            bus.Opcode   = opcTab[sent % 4];
            case (sent % 3)
                0:       begin bus.ALUOp = 2'b00; e.ctrl = 4'h2; end
                1:       begin bus.ALUOp = 2'b01; e.ctrl = 4'h7; end
                default: begin bus.ALUOp = 2'b10; e.ctrl = ctrlTab[sent % 4]; end
            endcase
            e.a = bus.RegA;
            e.b = bus.ALUSrc ? bus.Imm : bus.RegB;
            if (bus.OutValid && bus.OutReady) begin
                if (expQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL stream extra op: got BusA %h, expected none", bus.BusA);
                end else begin
                    exp_t f;
                    f = expQ.pop_front();
                    cmp("stream BusA", bus.BusA, f.a);
                    cmp("stream BusB", bus.BusB, f.b);
                    cmp("stream ALUCtrl", {60'd0, bus.ALUCtrl}, {60'd0, f.ctrl});
                end
                recv++;
            end
            if (bus.InValid && bus.InReady) begin
                expQ.push_back(e);
                sent++;
            end
            step();
        end
        bus.InValid  = 1'b0;
        bus.OutReady = 1'b1;
        cmp("stream received count", 64'(recv), 64'd100);
        cmp("stream queue empty", 64'(expQ.size()), 64'd0);
        step();
        cmp("stream no duplicate", {63'd0, bus.OutValid}, 64'd0);
    endtask

    task automatic test_flush();
        bus.OutReady = 1'b0;
        drive(1'b1, 2'b00, 11'd0, 1'b0, 64'hC1, 64'd0, 64'd0);
        step();
        drive(1'b1, 2'b00, 11'd0, 1'b0, 64'hC2, 64'd0, 64'd0);
        step();
        cmp("flush setup full", {63'd0, bus.InReady}, 64'd0);
        drive(1'b1, 2'b00, 11'd0, 1'b0, 64'hC3, 64'd0, 64'd0);
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        bus.InValid = 1'b0;
        cmp("flush OutValid", {63'd0, bus.OutValid}, 64'd0);
        cmp("flush InReady", {63'd0, bus.InReady}, 64'd1);
        bus.OutReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            cmp("flush nothing emitted", {63'd0, bus.OutValid}, 64'd0);
        end
        // an op offered with room available is still dropped by Flush
        drive(1'b1, 2'b00, 11'd0, 1'b0, 64'hC4, 64'd0, 64'd0);
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        bus.InValid = 1'b0;
        cmp("flush drops offered op", {63'd0, bus.OutValid}, 64'd0);
    endtask

    task automatic test_illegal();
        bus.OutReady = 1'b1;
        drive(1'b1, 2'b10, 11'd0, 1'b0, 64'hD1, 64'hD2, 64'd0);
        step();
        bus.InValid = 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        cmp("illegal opc trapped OutValid", {63'd0, bus.OutValid}, 64'd0);
        cmp("illegal opc IllegalOp", {63'd0, IllegalOp}, 64'd1);
`else
        cmp("illegal opc OutValid", {63'd0, bus.OutValid}, 64'd1);
        cmp("illegal opc ALUCtrl", {60'd0, bus.ALUCtrl}, 64'hF);
        cmp("illegal opc IllegalOp", {63'd0, IllegalOp}, 64'd0);
`endif
        drive(1'b1, 2'b11, 11'b10001011000, 1'b0, 64'hD3, 64'hD4, 64'd0);
        step();
        bus.InValid = 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        cmp("illegal aluop trapped OutValid", {63'd0, bus.OutValid}, 64'd0);
        cmp("illegal aluop IllegalOp sticky", {63'd0, IllegalOp}, 64'd1);
`else
        cmp("illegal aluop ALUCtrl", {60'd0, bus.ALUCtrl}, 64'hF);
        cmp("illegal aluop BusA", bus.BusA, 64'hD3);
`endif
        step();
    endtask

    task automatic test_reset_midstream();
        bus.OutReady = 1'b0;
        drive(1'b1, 2'b01, 11'd0, 1'b0, 64'hE1, 64'hE2, 64'd0);
        step();
        drive(1'b1, 2'b01, 11'd0, 1'b0, 64'hE3, 64'hE4, 64'd0);
        step();
        bus.InValid = 1'b0;
        cmp("midreset setup BusA", bus.BusA, 64'hE1);
        #2;
        Reset = 1'b1;
        #1;
        cmp("midreset OutValid", {63'd0, bus.OutValid}, 64'd0);
        cmp("midreset InReady", {63'd0, bus.InReady}, 64'd1);
        cmp("midreset BusA", bus.BusA, 64'd0);
        cmp("midreset BusB", bus.BusB, 64'd0);
        cmp("midreset ALUCtrl", {60'd0, bus.ALUCtrl}, 64'd0);
        cmp("midreset IllegalOp", {63'd0, IllegalOp}, 64'd0);
        step();
        Reset = 1'b0;
        bus.OutReady = 1'b1;
        step();
        cmp("midreset ops discarded", {63'd0, bus.OutValid}, 64'd0);
    endtask

    initial begin
        test_reset();
        test_rtype_add();
        test_imm_passb();
        test_backpressure();
        test_back_to_back();
        test_stream();
        test_flush();
        test_illegal();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
